// File: rtl/iram_axi_arb_pkg.sv
// Shared types and constants for the two-master iram AXI4-Lite arbiter.
//   arb_state_e     : arbiter FSM state encoding
//   AXI_RESP_OKAY   : AXI OKAY response code
//   AXI_RESP_SLVERR : AXI SLVERR response code (used for response timeouts)
package iram_axi_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_WADDR = 3'd1,
        ARB_WRESP = 3'd2,
        ARB_RADDR = 3'd3,
        ARB_RRESP = 3'd4
    } arb_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/iram_axi_arb_rr_arb2.sv
// 2-way round-robin grant, purely combinational.
//   req[1:0] : request per master
//   lp       : index of the master granted last; the other one wins a tie
//   gnt      : index of the granted master (only meaningful when |req)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       lp,
    output logic       gnt
);

    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~lp;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/iram_axi_arb.sv
// Two-master AXI4-Lite arbiter in front of the iram slave port.
// M0 = core load/store path, M1 = debug/ISP loader. One transaction at a time;
// the granted master's AW/W or AR is forwarded to the slave and the B/R
// response is routed back. The non-owner sees all ready/valid outputs at 0.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   m0_axi_*, m1_axi_* : AXI4-Lite slave-side ports facing the two masters
//   s_axi_*            : AXI4-Lite master-side port toward iram
// Optional feature: define IRAM_ARB_TIMEOUT_EN to enable the response-wait
// timeout (TIMEOUT cycles, then a local SLVERR response to the owner).
module iram_axi_arb
    import iram_axi_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    // master 0
    input  logic [ADDR_W-1:0]   m0_axi_awaddr,
    input  logic [2:0]          m0_axi_awprot,
    input  logic                m0_axi_awvalid,
    output logic                m0_axi_awready,
    input  logic [DATA_W-1:0]   m0_axi_wdata,
    input  logic [DATA_W/8-1:0] m0_axi_wstrb,
    input  logic                m0_axi_wvalid,
    output logic                m0_axi_wready,
    output logic [1:0]          m0_axi_bresp,
    output logic                m0_axi_bvalid,
    input  logic                m0_axi_bready,
    input  logic [ADDR_W-1:0]   m0_axi_araddr,
    input  logic [2:0]          m0_axi_arprot,
    input  logic                m0_axi_arvalid,
    output logic                m0_axi_arready,
    output logic [DATA_W-1:0]   m0_axi_rdata,
    output logic [1:0]          m0_axi_rresp,
    output logic                m0_axi_rvalid,
    input  logic                m0_axi_rready,
    // master 1
    input  logic [ADDR_W-1:0]   m1_axi_awaddr,
    input  logic [2:0]          m1_axi_awprot,
    input  logic                m1_axi_awvalid,
    output logic                m1_axi_awready,
    input  logic [DATA_W-1:0]   m1_axi_wdata,
    input  logic [DATA_W/8-1:0] m1_axi_wstrb,
    input  logic                m1_axi_wvalid,
    output logic                m1_axi_wready,
    output logic [1:0]          m1_axi_bresp,
    output logic                m1_axi_bvalid,
    input  logic                m1_axi_bready,
    input  logic [ADDR_W-1:0]   m1_axi_araddr,
    input  logic [2:0]          m1_axi_arprot,
    input  logic                m1_axi_arvalid,
    output logic                m1_axi_arready,
    output logic [DATA_W-1:0]   m1_axi_rdata,
    output logic [1:0]          m1_axi_rresp,
    output logic                m1_axi_rvalid,
    input  logic                m1_axi_rready,
    // slave (iram)
    output logic [ADDR_W-1:0]   s_axi_awaddr,
    output logic [2:0]          s_axi_awprot,
    output logic                s_axi_awvalid,
    input  logic                s_axi_awready,
    output logic [DATA_W-1:0]   s_axi_wdata,
    output logic [DATA_W/8-1:0] s_axi_wstrb,
    output logic                s_axi_wvalid,
    input  logic                s_axi_wready,
    input  logic [1:0]          s_axi_bresp,
    input  logic                s_axi_bvalid,
    output logic                s_axi_bready,
    output logic [ADDR_W-1:0]   s_axi_araddr,
    output logic [2:0]          s_axi_arprot,
    output logic                s_axi_arvalid,
    input  logic                s_axi_arready,
    input  logic [DATA_W-1:0]   s_axi_rdata,
    input  logic [1:0]          s_axi_rresp,
    input  logic                s_axi_rvalid,
    output logic                s_axi_rready
);

    arb_state_e state_q, state_d;
    logic       own_q, own_d;
    logic       lp_q, lp_d;
    logic       to_q;          // response timeout has fired for this transaction

    logic [1:0] wreq, rreq;
    logic       gnt;

    // AW and W must be presented together to count as a write request
    assign wreq = {m1_axi_awvalid & m1_axi_wvalid, m0_axi_awvalid & m0_axi_wvalid};
    assign rreq = {m1_axi_arvalid, m0_axi_arvalid};

    rr_arb2 u_rr_arb2 (
        .req (wreq | rreq),
        .lp  (lp_q),
        .gnt (gnt)
    );

    // owner's request-side signals
    logic [ADDR_W-1:0]   sel_awaddr, sel_araddr;
    logic [2:0]          sel_awprot, sel_arprot;
    logic                sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_wstrb;

    assign sel_awaddr  = own_q ? m1_axi_awaddr  : m0_axi_awaddr;
    assign sel_awprot  = own_q ? m1_axi_awprot  : m0_axi_awprot;
    assign sel_awvalid = own_q ? m1_axi_awvalid : m0_axi_awvalid;
    assign sel_wdata   = own_q ? m1_axi_wdata   : m0_axi_wdata;
    assign sel_wstrb   = own_q ? m1_axi_wstrb   : m0_axi_wstrb;
    assign sel_wvalid  = own_q ? m1_axi_wvalid  : m0_axi_wvalid;
    assign sel_bready  = own_q ? m1_axi_bready  : m0_axi_bready;
    assign sel_araddr  = own_q ? m1_axi_araddr  : m0_axi_araddr;
    assign sel_arprot  = own_q ? m1_axi_arprot  : m0_axi_arprot;
    assign sel_arvalid = own_q ? m1_axi_arvalid : m0_axi_arvalid;
    assign sel_rready  = own_q ? m1_axi_rready  : m0_axi_rready;

    // owner's response-side signals, steered to one master below
    logic              o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]        o_bresp, o_rresp;
    logic [DATA_W-1:0] o_rdata;

    always_comb begin
        state_d       = state_q;
        own_d         = own_q;
        lp_d          = lp_q;
        s_axi_awaddr  = '0;
        s_axi_awprot  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arprot  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        o_awready     = 1'b0;
        o_wready      = 1'b0;
        o_bvalid      = 1'b0;
        o_bresp       = AXI_RESP_OKAY;
        o_arready     = 1'b0;
        o_rvalid      = 1'b0;
        o_rresp       = AXI_RESP_OKAY;
        o_rdata       = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|(wreq | rreq)) begin
                    own_d   = gnt;
                    state_d = wreq[gnt] ? ARB_WADDR : ARB_RADDR;
                end
            end
            ARB_WADDR: begin
                s_axi_awaddr  = sel_awaddr;
                s_axi_awprot  = sel_awprot;
                s_axi_awvalid = sel_awvalid;
                s_axi_wdata   = sel_wdata;
                s_axi_wstrb   = sel_wstrb;
                s_axi_wvalid  = sel_wvalid;
                // AW and W are accepted together so the slave never sees a split write
                o_awready     = s_axi_awready & s_axi_wready;
                o_wready      = s_axi_awready & s_axi_wready;
                if (sel_awvalid && sel_wvalid && s_axi_awready && s_axi_wready)
                    state_d = ARB_WRESP;
            end
            ARB_WRESP: begin
                if (to_q) begin
                    o_bvalid = 1'b1;
                    o_bresp  = AXI_RESP_SLVERR;
                    if (sel_bready) begin
                        state_d = ARB_IDLE;
                        lp_d    = own_q;
                    end
                end else begin
                    o_bvalid     = s_axi_bvalid;
                    o_bresp      = s_axi_bresp;
                    s_axi_bready = sel_bready;
                    if (s_axi_bvalid && sel_bready) begin
                        state_d = ARB_IDLE;
                        lp_d    = own_q;
                    end
                end
            end
            ARB_RADDR: begin
                s_axi_araddr  = sel_araddr;
                s_axi_arprot  = sel_arprot;
                s_axi_arvalid = sel_arvalid;
                o_arready     = s_axi_arready;
                if (sel_arvalid && s_axi_arready)
                    state_d = ARB_RRESP;
            end
            ARB_RRESP: begin
                if (to_q) begin
                    o_rvalid = 1'b1;
                    o_rresp  = AXI_RESP_SLVERR;
                    if (sel_rready) begin
                        state_d = ARB_IDLE;
                        lp_d    = own_q;
                    end
                end else begin
                    o_rvalid     = s_axi_rvalid;
                    o_rresp      = s_axi_rresp;
                    o_rdata      = s_axi_rdata;
                    s_axi_rready = sel_rready;
                    if (s_axi_rvalid && sel_rready) begin
                        state_d = ARB_IDLE;
                        lp_d    = own_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

`ifdef IRAM_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_d;
    logic       resp_hs;

    assign resp_hs = (state_q == ARB_WRESP) ? (s_axi_bvalid & sel_bready)
                                            : (s_axi_rvalid & sel_rready);

    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (state_d != state_q) begin
            // any state change either enters a response phase or leaves it
            cnt_d = 8'd0;
            to_d  = 1'b0;
        end else if ((state_q == ARB_WRESP || state_q == ARB_RRESP) && !to_q && !resp_hs) begin
            if (cnt_q == TIMEOUT[7:0])
                to_d = 1'b1;
            else
                cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    assign to_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            own_q   <= 1'b0;
            lp_q    <= 1'b1;    // M0 wins the first tie
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            lp_q    <= lp_d;
        end
    end

    assign m0_axi_awready = ~own_q & o_awready;
    assign m0_axi_wready  = ~own_q & o_wready;
    assign m0_axi_bvalid  = ~own_q & o_bvalid;
    assign m0_axi_bresp   = own_q ? 2'b00 : o_bresp;
    assign m0_axi_arready = ~own_q & o_arready;
    assign m0_axi_rvalid  = ~own_q & o_rvalid;
    assign m0_axi_rresp   = own_q ? 2'b00 : o_rresp;
    assign m0_axi_rdata   = own_q ? '0 : o_rdata;

    assign m1_axi_awready = own_q & o_awready;
    assign m1_axi_wready  = own_q & o_wready;
    assign m1_axi_bvalid  = own_q & o_bvalid;
    assign m1_axi_bresp   = own_q ? o_bresp : 2'b00;
    assign m1_axi_arready = own_q & o_arready;
    assign m1_axi_rvalid  = own_q & o_rvalid;
    assign m1_axi_rresp   = own_q ? o_rresp : 2'b00;
    assign m1_axi_rdata   = own_q ? o_rdata : '0;

endmodule

// File: tb/tb_iram_axi_arb.sv
// Directed testbench for iram_axi_arb. A small iram model answers every
// address handshake one cycle later; read data is address ^ 32'h5A5A_0000.
module tb_iram_axi_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
    logic [2:0]  m0_awprot, m0_arprot;
    logic [3:0]  m0_wstrb;
    logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [1:0]  m0_bresp, m0_rresp;
    logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
    logic [2:0]  m1_awprot, m1_arprot;
    logic [3:0]  m1_wstrb;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [1:0]  m1_bresp, m1_rresp;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;

    // iram model
    logic        slv_b_en;
    logic        b_pend, r_pend;
    logic [31:0] r_data;

    always #5 clk = ~clk;

    iram_axi_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_axi_awaddr(m0_awaddr), .m0_axi_awprot(m0_awprot), .m0_axi_awvalid(m0_awvalid),
        .m0_axi_awready(m0_awready), .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb),
        .m0_axi_wvalid(m0_wvalid), .m0_axi_wready(m0_wready), .m0_axi_bresp(m0_bresp),
        .m0_axi_bvalid(m0_bvalid), .m0_axi_bready(m0_bready), .m0_axi_araddr(m0_araddr),
        .m0_axi_arprot(m0_arprot), .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(m0_arready),
        .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp), .m0_axi_rvalid(m0_rvalid),
        .m0_axi_rready(m0_rready),
        .m1_axi_awaddr(m1_awaddr), .m1_axi_awprot(m1_awprot), .m1_axi_awvalid(m1_awvalid),
        .m1_axi_awready(m1_awready), .m1_axi_wdata(m1_wdata), .m1_axi_wstrb(m1_wstrb),
        .m1_axi_wvalid(m1_wvalid), .m1_axi_wready(m1_wready), .m1_axi_bresp(m1_bresp),
        .m1_axi_bvalid(m1_bvalid), .m1_axi_bready(m1_bready), .m1_axi_araddr(m1_araddr),
        .m1_axi_arprot(m1_arprot), .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(m1_arready),
        .m1_axi_rdata(m1_rdata), .m1_axi_rresp(m1_rresp), .m1_axi_rvalid(m1_rvalid),
        .m1_axi_rready(m1_rready),
        .s_axi_awaddr(s_awaddr), .s_axi_awprot(s_awprot), .s_axi_awvalid(s_awvalid),
        .s_axi_awready(s_awready), .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb),
        .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready), .s_axi_bresp(s_bresp),
        .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready), .s_axi_araddr(s_araddr),
        .s_axi_arprot(s_arprot), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid),
        .s_axi_rready(s_rready)
    );

    // Reset is sampled synchronously here so s_rvalid stays visible while
    // the arbiter itself is held in reset.
    always @(posedge clk) begin
        if (rst) begin
            b_pend <= 1'b0;
            r_pend <= 1'b0;
            r_data <= 32'h0;
        end else begin
            if (s_awvalid && s_awready && s_wvalid && s_wready && slv_b_en) b_pend <= 1'b1;
            else if (s_bvalid && s_bready) b_pend <= 1'b0;
            if (s_arvalid && s_arready) begin
                r_pend <= 1'b1;
                r_data <= s_araddr ^ 32'h5A5A_0000;
            end else if (s_rvalid && s_rready) r_pend <= 1'b0;
        end
    end
    assign s_bvalid = b_pend;
    assign s_rvalid = r_pend;
    assign s_rdata  = r_data;
    assign s_bresp  = 2'b00;
    assign s_rresp  = 2'b00;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_awaddr = 0; m0_awprot = 0; m0_awvalid = 0; m0_wdata = 0; m0_wstrb = 0; m0_wvalid = 0;
        m0_bready = 0; m0_araddr = 0; m0_arprot = 0; m0_arvalid = 0; m0_rready = 0;
        m1_awaddr = 0; m1_awprot = 0; m1_awvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wvalid = 0;
        m1_bready = 0; m1_araddr = 0; m1_arprot = 0; m1_arvalid = 0; m1_rready = 0;
        s_awready = 1; s_wready = 1; s_arready = 1; slv_b_en = 1;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        m0_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
        tick();
        tick();
        checks++;
        if ({m0_arready, m0_awready, m1_awready, m1_wready, m1_arready} !== 5'b0) begin
            errors++; $display("FAIL reset_ready got %b want 00000",
                {m0_arready, m0_awready, m1_awready, m1_wready, m1_arready});
        end
        checks++;
        if ({s_arvalid, s_awvalid, s_wvalid, s_bready, s_rready} !== 5'b0) begin
            errors++; $display("FAIL reset_slave got %b want 00000",
                {s_arvalid, s_awvalid, s_wvalid, s_bready, s_rready});
        end
        do_reset();
    endtask

    task automatic test_write;
        do_reset();
        m0_awaddr = 32'h10; m0_awvalid = 1; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
        m0_wvalid = 1; m0_bready = 1;
        #1;
        checks++;
        if (s_awvalid !== 1'b0 || m0_awready !== 1'b0) begin
            errors++; $display("FAIL wr_idle s_awvalid %b awready %b want 0 0", s_awvalid, m0_awready);
        end
        tick();   // cycle 1: WADDR
        checks++;
        if (s_awaddr !== 32'h10 || s_wdata !== 32'hDEADBEEF || s_wstrb !== 4'hF || s_awvalid !== 1'b1) begin
            errors++; $display("FAIL wr_fwd awaddr %h wdata %h strb %h valid %b want 10 deadbeef f 1",
                s_awaddr, s_wdata, s_wstrb, s_awvalid);
        end
        checks++;
        if (m0_awready !== 1'b1 || m0_wready !== 1'b1) begin
            errors++; $display("FAIL wr_ready aw %b w %b want 1 1", m0_awready, m0_wready);
        end
        tick();   // cycle 2: WRESP
        m0_awvalid = 0; m0_wvalid = 0;
        checks++;
        if (m0_bvalid !== 1'b1 || m0_bresp !== 2'b00 || m1_bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_bresp m0 bvalid %b resp %b m1 bvalid %b want 1 00 0",
                m0_bvalid, m0_bresp, m1_bvalid);
        end
        tick();   // cycle 3: IDLE
        checks++;
        if (m0_bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_done bvalid %b want 0", m0_bvalid);
        end
        m0_bready = 0;
    endtask

    task automatic test_dual_read;
        do_reset();
        m0_araddr = 32'h100; m0_arvalid = 1; m0_rready = 1;
        m1_araddr = 32'h200; m1_arvalid = 1; m1_rready = 1;
        tick();   // cycle 1: RADDR own M0
        checks++;
        if (s_araddr !== 32'h100 || m0_arready !== 1'b1 || m1_arready !== 1'b0) begin
            errors++; $display("FAIL rd2_first araddr %h m0 %b m1 %b want 100 1 0",
                s_araddr, m0_arready, m1_arready);
        end
        tick();   // cycle 2: RRESP
        m0_arvalid = 0;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h5A5A_0100 || m1_rvalid !== 1'b0 || m1_arready !== 1'b0) begin
            errors++; $display("FAIL rd2_m0data rvalid %b rdata %h m1 rvalid %b arready %b want 1 5a5a0100 0 0",
                m0_rvalid, m0_rdata, m1_rvalid, m1_arready);
        end
        tick();   // cycle 3: IDLE
        checks++;
        if (m1_arready !== 1'b0 || m0_rvalid !== 1'b0) begin
            errors++; $display("FAIL rd2_gap m1 arready %b m0 rvalid %b want 0 0", m1_arready, m0_rvalid);
        end
        tick();   // cycle 4: RADDR own M1
        checks++;
        if (s_araddr !== 32'h200 || m1_arready !== 1'b1 || m0_arready !== 1'b0) begin
            errors++; $display("FAIL rd2_second araddr %h m1 %b m0 %b want 200 1 0",
                s_araddr, m1_arready, m0_arready);
        end
        tick();   // cycle 5: RRESP
        m1_arvalid = 0;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h5A5A_0200 || m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
            errors++; $display("FAIL rd2_m1data rvalid %b rdata %h m0 rvalid %b rdata %h want 1 5a5a0200 0 0",
                m1_rvalid, m1_rdata, m0_rvalid, m0_rdata);
        end
        tick();
    endtask

    task automatic test_write_before_read;
        do_reset();
        m1_awaddr = 32'h44; m1_awvalid = 1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'h3; m1_wvalid = 1;
        m1_araddr = 32'h88; m1_arvalid = 1; m1_bready = 1; m1_rready = 1;
        tick();   // cycle 1: WADDR
        checks++;
        if (s_awvalid !== 1'b1 || s_awaddr !== 32'h44 || s_arvalid !== 1'b0 || m1_awready !== 1'b1 || m1_arready !== 1'b0) begin
            errors++; $display("FAIL wr1st s_awvalid %b awaddr %h s_arvalid %b awready %b arready %b want 1 44 0 1 0",
                s_awvalid, s_awaddr, s_arvalid, m1_awready, m1_arready);
        end
        tick();   // cycle 2: WRESP
        m1_awvalid = 0; m1_wvalid = 0;
        checks++;
        if (m1_bvalid !== 1'b1 || m1_arready !== 1'b0) begin
            errors++; $display("FAIL wr1st_b bvalid %b arready %b want 1 0", m1_bvalid, m1_arready);
        end
        tick();   // cycle 3: IDLE
        checks++;
        if (m1_arready !== 1'b0 || s_arvalid !== 1'b0) begin
            errors++; $display("FAIL wr1st_gap arready %b s_arvalid %b want 0 0", m1_arready, s_arvalid);
        end
        tick();   // cycle 4: RADDR
        checks++;
        if (m1_arready !== 1'b1 || s_araddr !== 32'h88) begin
            errors++; $display("FAIL rd2nd arready %b araddr %h want 1 88", m1_arready, s_araddr);
        end
        tick();   // cycle 5: RRESP
        m1_arvalid = 0;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h5A5A_0088) begin
            errors++; $display("FAIL rd2nd_data rvalid %b rdata %h want 1 5a5a0088", m1_rvalid, m1_rdata);
        end
        tick();
        m1_bready = 0; m1_rready = 0;
    endtask

    task automatic test_back_to_back;
        logic exp_order [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   n = 0;
        do_reset();
        m0_araddr = 32'h300; m0_arvalid = 1; m0_rready = 1;
        m1_araddr = 32'h400; m1_arvalid = 1; m1_rready = 1;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            tick();
            if (m0_arready || m1_arready) begin
                checks++;
                if (m1_arready !== exp_order[n] || (m0_arready & m1_arready) !== 1'b0) begin
                    errors++; $display("FAIL b2b_grant%0d m0 %b m1 %b want master %0d",
                        n, m0_arready, m1_arready, exp_order[n]);
                end
                n++;
            end
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL b2b_count got %0d grants want 6", n);
        end
        tick();
        m0_arvalid = 0; m1_arvalid = 0;
        tick();
        tick();
    endtask

    task automatic test_single_master;
        int g1 = 0;
        int g0 = 0;
        do_reset();
        m1_araddr = 32'h500; m1_arvalid = 1; m1_rready = 1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            tick();
            if (m1_arready) g1++;
            if (m0_arready) g0++;
        end
        m1_arvalid = 0;
        checks++;
        if (g1 !== 3 || g0 !== 0) begin
            errors++; $display("FAIL single_master m1 grants %0d m0 grants %0d want 3 0", g1, g0);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        m0_araddr = 32'h40; m0_arvalid = 1; m0_rready = 0;
        tick();   // RADDR
        tick();   // RRESP, response pending
        m0_arvalid = 0;
        checks++;
        if (m0_rvalid !== 1'b1 || s_rvalid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre m0 rvalid %b s_rvalid %b want 1 1", m0_rvalid, s_rvalid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || m0_rresp !== 2'b00 || s_rready !== 1'b0) begin
            errors++; $display("FAIL rstmid_out rvalid %b rdata %h rresp %b s_rready %b want 0 0 00 0",
                m0_rvalid, m0_rdata, m0_rresp, s_rready);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        m0_araddr = 32'h80; m0_arvalid = 1; m0_rready = 1;
        tick();
        checks++;
        if (m0_arready !== 1'b1 || s_araddr !== 32'h80) begin
            errors++; $display("FAIL rstmid_after arready %b araddr %h want 1 80", m0_arready, s_araddr);
        end
        tick();
        m0_arvalid = 0;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h5A5A_0080) begin
            errors++; $display("FAIL rstmid_data rvalid %b rdata %h want 1 5a5a0080", m0_rvalid, m0_rdata);
        end
        tick();
    endtask

`ifdef IRAM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        slv_b_en = 0;
        m0_awaddr = 32'h20; m0_awvalid = 1; m0_wdata = 32'hCAFE; m0_wstrb = 4'hF; m0_wvalid = 1;
        m0_bready = 0;
        tick();   // WADDR
        tick();   // first WRESP cycle
        m0_awvalid = 0; m0_wvalid = 0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (m0_bvalid !== 1'b0) begin
                errors++; $display("FAIL to_wait%0d bvalid %b want 0", i, m0_bvalid);
            end
            tick();
        end
        checks++;
        if (m0_bvalid !== 1'b1 || m0_bresp !== 2'b10 || s_bready !== 1'b0) begin
            errors++; $display("FAIL to_fire bvalid %b bresp %b s_bready %b want 1 10 0",
                m0_bvalid, m0_bresp, s_bready);
        end
        tick();
        checks++;
        if (m0_bvalid !== 1'b1 || m0_bresp !== 2'b10) begin
            errors++; $display("FAIL to_hold bvalid %b bresp %b want 1 10", m0_bvalid, m0_bresp);
        end
        m0_bready = 1;
        tick();
        checks++;
        if (m0_bvalid !== 1'b0 || m0_bresp !== 2'b00) begin
            errors++; $display("FAIL to_idle bvalid %b bresp %b want 0 00", m0_bvalid, m0_bresp);
        end
        m0_bready = 0;
        slv_b_en = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_dual_read();
        test_write_before_read();
        test_back_to_back();
        test_single_master();
        test_reset_mid();
`ifdef IRAM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
